// File: rtl/dff_bank_arbiter.sv
// ---------------------------------------------------------------------------
// dff_bank_arbiter : round-robin, 4-phase REQ/ACK owner of a shared DFF bank
//                    with write/readback verification.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dff_bank_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic [NREQ-1:0]       REQ,
   input  logic [NREQ*WIDTH-1:0] DIN,
   input  logic [WIDTH-1:0]      Q,
   output logic [WIDTH-1:0]      D,
   output logic                  ENA,
   output logic [NREQ-1:0]       GNT,
   output logic [NREQ-1:0]       ACK,
   output logic [WIDTH-1:0]      RDATA,
   output logic                  BUSY,
   output logic                  ERR
);

   localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WRITE   = 2'd1,
      S_VERIFY  = 2'd2,
      S_RELEASE = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [IDXW-1:0]   last_q, last_d;
   logic [IDXW-1:0]   owner_q, owner_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [NREQ-1:0]   ack_q, ack_d;
   logic [WIDTH-1:0]  wdata_q, wdata_d;
   logic [WIDTH-1:0]  rdata_q, rdata_d;
   logic              ena_q, ena_d;
   logic              err_q, err_d;

   logic [WIDTH-1:0]  din_arr [NREQ];
   logic              sel_found;
   logic [IDXW-1:0]   sel_idx;
   logic [IDXW-1:0]   cand_idx;
   int                cand;

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign din_arr[i] = DIN[i*WIDTH +: WIDTH];
   end

   // Round-robin search starting one past the last served requester.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = 0;
      cand_idx  = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = int'(last_q) + k;
         if (cand >= NREQ) begin
            cand = cand - NREQ;
         end
         cand_idx = IDXW'(cand);
         if (!sel_found && REQ[cand_idx]) begin
            sel_found = 1'b1;
            sel_idx   = cand_idx;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      owner_d = owner_q;
      gnt_d   = gnt_q;
      ack_d   = '0;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      ena_d   = 1'b0;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (sel_found) begin
               gnt_d          = '0;
               gnt_d[sel_idx] = 1'b1;
               owner_d        = sel_idx;
               wdata_d        = din_arr[sel_idx];
               ena_d          = 1'b1;
               state_d        = S_WRITE;
            end
         end
         S_WRITE: begin
            // ACK is registered here so it is visible during VERIFY.
            ack_d   = gnt_q;
            state_d = S_VERIFY;
         end
         S_VERIFY: begin
            rdata_d = Q;
            if (Q != wdata_q) begin
               err_d = 1'b1;
            end
            last_d  = owner_q;
            state_d = S_RELEASE;
         end
         S_RELEASE: begin
            if (!REQ[owner_q]) begin
               gnt_d   = '0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= S_IDLE;
         last_q  <= IDXW'(NREQ - 1);
         owner_q <= '0;
         gnt_q   <= '0;
         ack_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         ena_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         owner_q <= owner_d;
         gnt_q   <= gnt_d;
         ack_q   <= ack_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         ena_q   <= ena_d;
         err_q   <= err_d;
      end
   end

   assign D     = wdata_q;
   assign ENA   = ena_q;
   assign GNT   = gnt_q;
   assign ACK   = ack_q;
   assign RDATA = rdata_q;
   assign BUSY  = (state_q != S_IDLE);
   assign ERR   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_dff_bank_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dff_bank_arbiter : directed self-checking bench with a behavioural bank.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dff_bank_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;

   logic                  CLK;
   logic                  RST_N;
   logic [NREQ-1:0]       REQ;
   logic [NREQ*WIDTH-1:0] DIN;
   logic [WIDTH-1:0]      Q;
   logic [WIDTH-1:0]      D;
   logic                  ENA;
   logic [NREQ-1:0]       GNT;
   logic [NREQ-1:0]       ACK;
   logic [WIDTH-1:0]      RDATA;
   logic                  BUSY;
   logic                  ERR;

   logic                  stuck;
   logic [WIDTH-1:0]      bank_q;
   int                    n_assert;
   int                    n_fail;
   int                    ord [5];

   dff_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .REQ   (REQ),
      .DIN   (DIN),
      .Q     (Q),
      .D     (D),
      .ENA   (ENA),
      .GNT   (GNT),
      .ACK   (ACK),
      .RDATA (RDATA),
      .BUSY  (BUSY),
      .ERR   (ERR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Shared register bank; stuck forces a bad readback.
   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         bank_q <= '0;
      end else if (ENA) begin
         bank_q <= stuck ? '0 : D;
      end
   end
   assign Q = bank_q;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge CLK);
   endtask

   task automatic wait_ack();
      for (int i = 0; i < 12; i++) begin
         if (ACK != '0) break;
         step();
      end
      chk("ack_seen", {31'd0, (ACK != '0)}, 32'd1);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 12; i++) begin
         if (!BUSY) break;
         step();
      end
      chk("idle_seen", {31'd0, BUSY}, 32'd0);
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      ord      = '{0, 1, 2, 3, 0};
      RST_N    = 1'b0;
      REQ      = '0;
      DIN      = '0;
      stuck    = 1'b0;

      #1;
      chk("rst_gnt",   GNT,   0);
      chk("rst_ena",   ENA,   0);
      chk("rst_busy",  BUSY,  0);
      chk("rst_ack",   ACK,   0);
      chk("rst_d",     D,     0);
      chk("rst_err",   ERR,   0);
      chk("rst_rdata", RDATA, 0);
      step();
      step();
      RST_N = 1'b1;

      // Single request from requester 1
      REQ        = 4'b0010;
      DIN[15:8]  = 8'hA5;
      step();
      chk("t2_gnt",  GNT,  4'b0010);
      chk("t2_ena",  ENA,  1);
      chk("t2_d",    D,    8'hA5);
      chk("t2_busy", BUSY, 1);
      DIN = '0;
      step();
      chk("t2_ack",   ACK, 4'b0010);
      chk("t2_ena_0", ENA, 0);
      step();
      chk("t2_rdata", RDATA, 8'hA5);
      chk("t2_ack_0", ACK,   0);
      chk("t2_gnt_h", GNT,   4'b0010);
      chk("t2_err",   ERR,   0);
      REQ = '0;
      step();
      chk("t2_idle", BUSY, 0);
      chk("t2_gnt0", GNT,  0);

      // Reset while ENA is high
      REQ       = 4'b0001;
      DIN[7:0]  = 8'h5A;
      step();
      chk("t4_ena", ENA, 1);
      #2 RST_N = 1'b0;
      #1;
      chk("t4_ena_async",   ENA,   0);
      chk("t4_gnt_async",   GNT,   0);
      chk("t4_d_async",     D,     0);
      chk("t4_busy_async",  BUSY,  0);
      chk("t4_rdata_async", RDATA, 0);
      step();
      chk("t4_ena_held", ENA, 0);
      chk("t4_ack_none", ACK, 0);
      REQ   = 4'b1010;
      RST_N = 1'b1;
      step();
      chk("t4_first_gnt", GNT, 4'b0010);
      REQ = '0;
      wait_ack();
      chk("t4_ack_after_drop", ACK, 4'b0010);
      step();
      step();
      chk("t4_idle", BUSY, 0);

      // Round-robin fairness from a fresh pointer
      RST_N = 1'b0;
      step();
      RST_N = 1'b1;
      REQ   = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_ack();
         chk("t3_ack_order", ACK, 32'd1 << ord[k]);
         chk("t3_gnt_order", GNT, 32'd1 << ord[k]);
         step();
         REQ[ord[k]] = 1'b0;
         wait_idle();
         if (k < 4) REQ[ord[k]] = 1'b1;
         else       REQ = '0;
      end
      step();
      chk("t3_no_grant", GNT, 0);
      chk("t3_no_busy",  BUSY, 0);

      // Stuck readback sets sticky ERR
      stuck     = 1'b1;
      DIN[7:0]  = 8'h3C;
      REQ       = 4'b0001;
      wait_ack();
      chk("t5_ack", ACK, 4'b0001);
      step();
      chk("t5_rdata", RDATA, 8'h00);
      chk("t5_err",   ERR,   1);
      REQ   = '0;
      stuck = 1'b0;
      step();
      chk("t5_idle", BUSY, 0);
      DIN[23:16] = 8'h77;
      REQ        = 4'b0100;
      wait_ack();
      chk("t5_ack2", ACK, 4'b0100);
      step();
      chk("t5_rdata2",  RDATA, 8'h77);
      chk("t5_err_hold", ERR,  1);
      REQ = '0;
      step();

      // Hold-off: owner keeps REQ high after its ACK
      REQ = 4'b0011;
      wait_ack();
      chk("t6_ack", ACK, 4'b0001);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t6_gnt_hold", GNT, 4'b0001);
      end
      REQ = 4'b0010;
      step();
      chk("t6_gnt_gap", GNT, 0);
      step();
      chk("t6_gnt_next", GNT, 4'b0010);
      REQ = '0;
      wait_ack();
      step();
      step();
      chk("t6_idle", BUSY, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
